// File: rtl/adc_conversion_scheduler_if.sv
// Bundle of signals between the ADC conversion scheduler and its surroundings.
//
// The "master" side owns the request inputs and the converter data (channel mux/ADC
// datapath plus register logic, or a testbench standing in for them). The "slave" side is
// the scheduler itself.
//
// Signals:
//   ch_req       per-channel request pulses
//   ch_enable    channel enable mask
//   abort        cancel the in-flight conversion
//   adc_data     converter digital output
//   adc_sel      analog mux select / channel under conversion
//   adc_start    one-cycle converter start pulse
//   busy         scheduler is not idle
//   pending      latched outstanding requests
//   result_valid one-cycle pulse qualifying result_ch/result_data
//   result_ch    channel of the last result
//   result_data  last captured conversion value
interface adc_conversion_scheduler_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] ch_req;
    logic [NUM_CH-1:0] ch_enable;
    logic              abort;
    logic [DATA_W-1:0] adc_data;
    logic [SEL_W-1:0]  adc_sel;
    logic              adc_start;
    logic              busy;
    logic [NUM_CH-1:0] pending;
    logic              result_valid;
    logic [SEL_W-1:0]  result_ch;
    logic [DATA_W-1:0] result_data;

    modport master (
        output ch_req,
        output ch_enable,
        output abort,
        output adc_data,
        input  adc_sel,
        input  adc_start,
        input  busy,
        input  pending,
        input  result_valid,
        input  result_ch,
        input  result_data
    );

    modport slave (
        input  ch_req,
        input  ch_enable,
        input  abort,
        input  adc_data,
        output adc_sel,
        output adc_start,
        output busy,
        output pending,
        output result_valid,
        output result_ch,
        output result_data
    );
endinterface

// File: rtl/adc_conversion_scheduler.sv
// Shares one pulse-width conversion ADC among NUM_CH analog channels.
//
// Requests are OR-latched into a pending vector. When idle, the next enabled pending
// channel is picked round-robin (search starts just after the last completed channel).
// The scheduler then drives the mux select, waits SETTLE_CYCLES for the front end to
// settle, pulses adc_start for one cycle, waits CONV_CYCLES for the converter and
// captures adc_data tagged with the channel number.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset, wins over every other input
//   bus  scheduler side (slave modport) of adc_conversion_scheduler_if; the interface
//        must be instantiated with the same NUM_CH and DATA_W as this module
//
// Timing, for a grant decided in IDLE at cycle T:
//   adc_start high at T+SETTLE_CYCLES+1, result_valid high at
//   T+SETTLE_CYCLES+CONV_CYCLES+2 (the CAPTURE cycle). IDLE always lasts at least one
//   cycle between conversions because arbitration only happens in IDLE.
module adc_conversion_scheduler #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CONV_CYCLES   = 769
) (
    input logic                      clk,
    input logic                      rst,
    adc_conversion_scheduler_if.slave bus
);

    localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned MAX_CYC = (SETTLE_CYCLES > CONV_CYCLES) ? SETTLE_CYCLES
                                                                     : CONV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StStart,
        StConvert,
        StCapture
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic              result_valid_q, result_valid_d;
    logic [SEL_W-1:0]  result_ch_q, result_ch_d;
    logic [DATA_W-1:0] result_data_q, result_data_d;

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] clear_mask;
    logic [SEL_W-1:0]  arb_idx;
    logic              grant_found;
    logic [SEL_W-1:0]  grant_ch;

    // Round-robin search: walk rr_ptr+1, rr_ptr+2, ... with wrap at NUM_CH, first hit wins.
    always_comb begin
        eligible    = pending_q & bus.ch_enable;
        grant_found = 1'b0;
        grant_ch    = '0;
        arb_idx     = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            arb_idx = (arb_idx == LAST_CH) ? '0 : arb_idx + 1'b1;
            if (!grant_found && eligible[arb_idx]) begin
                grant_found = 1'b1;
                grant_ch    = arb_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sel_d          = sel_q;
        rr_ptr_d       = rr_ptr_q;
        result_valid_d = 1'b0;
        result_ch_d    = result_ch_q;
        result_data_d  = result_data_q;
        clear_mask     = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    sel_d = grant_ch;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = StStart;
                    end else begin
                        state_d = StSettle;
                        cnt_d   = CNT_W'(SETTLE_CYCLES);
                    end
                end
            end
            StSettle: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStart: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    state_d = StConvert;
                    cnt_d   = CNT_W'(CONV_CYCLES);
                end
            end
            StConvert: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_W'(1)) begin
                    // Load the result registers on the way into CAPTURE so that
                    // result_valid/result_ch/result_data are all visible in CAPTURE.
                    state_d        = StCapture;
                    result_valid_d = 1'b1;
                    result_ch_d    = sel_q;
                    result_data_d  = bus.adc_data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCapture: begin
                // abort is deliberately ignored here: the result is already taken.
                state_d             = StIdle;
                rr_ptr_d            = sel_q;
                clear_mask[sel_q]   = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A request arriving in the same cycle as the clear keeps the bit set.
        pending_d = (pending_q & ~clear_mask) | bus.ch_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            sel_q          <= '0;
            rr_ptr_q       <= LAST_CH;
            pending_q      <= '0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sel_q          <= sel_d;
            rr_ptr_q       <= rr_ptr_d;
            pending_q      <= pending_d;
            result_valid_q <= result_valid_d;
            result_ch_q    <= result_ch_d;
            result_data_q  <= result_data_d;
        end
    end

    assign bus.adc_sel      = sel_q;
    // An abort coinciding with START suppresses the pulse.
    assign bus.adc_start    = (state_q == StStart) && !bus.abort;
    assign bus.busy         = (state_q != StIdle);
    assign bus.pending      = pending_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_ch    = result_ch_q;
    assign bus.result_data  = result_data_q;

endmodule
